// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: control from the pipeline, the instruction-memory read
// port, and the decode-side outputs. The master modport is the fetch unit.
interface inst_fetch_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_pc;
    logic                  stall;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic [DATA_WIDTH-1:0] if_inst;
    logic [ADDR_WIDTH-1:0] if_pc;
    logic                  if_valid;
    logic                  running;
    logic                  halted;
    logic [CNT_WIDTH-1:0]  fetch_count;

    modport master (
        input  start, start_pc, stall, redirect_valid, redirect_pc, imem_rdata,
        output imem_addr, if_inst, if_pc, if_valid, running, halted, fetch_count
    );

    modport slave (
        output start, start_pc, stall, redirect_valid, redirect_pc, imem_rdata,
        input  imem_addr, if_inst, if_pc, if_valid, running, halted, fetch_count
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, hides the 1-cycle synchronous imem read latency,
// and handles start/halt, decode stall and redirect-with-flush.
module inst_fetch #(
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] HALT_INST  = 32'hFFFF_FFFF,
    parameter int                    CNT_WIDTH  = 32
) (
    input logic         clk,
    input logic         rst,
    inst_fetch_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] rsp_pc_q;
    logic                  rsp_valid_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  accept;
    logic                  hold;

    assign accept = rsp_valid_q && !bus.stall && !bus.redirect_valid;
    assign hold   = bus.stall && rsp_valid_q;

    // While stalled, re-read the held address so imem_rdata stays put.
    assign bus.imem_addr   = hold ? rsp_pc_q : pc_q;
    assign bus.if_inst     = bus.imem_rdata;
    assign bus.if_pc       = rsp_pc_q;
    assign bus.if_valid    = rsp_valid_q;
    assign bus.running     = (state == RUN);
    assign bus.halted      = (state == HALTED);
    assign bus.fetch_count = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc_q        <= '0;
            rsp_pc_q    <= '0;
            rsp_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (bus.start) begin
                        pc_q        <= bus.start_pc;
                        cnt_q       <= '0;
                        rsp_valid_q <= 1'b0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (bus.redirect_valid) begin
                        // Flush: the word arriving now belongs to the old path.
                        pc_q        <= bus.redirect_pc;
                        rsp_valid_q <= 1'b0;
                    end else if (accept && bus.imem_rdata == HALT_INST) begin
                        cnt_q       <= cnt_q + CNT_WIDTH'(1);
                        rsp_valid_q <= 1'b0;
                        state       <= HALTED;
                    end else if (!hold) begin
                        rsp_pc_q    <= pc_q;
                        rsp_valid_q <= 1'b1;
                        pc_q        <= pc_q + ADDR_WIDTH'(1);
                        if (accept)
                            cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
